// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_pkg                                                              |
// | Shared types and constants for the 3BC run-control sequencer.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int CYC_W_DEF = 16;
  localparam int PC_W_DEF  = 10;

  // Entry points of the four resident programs, indexed by PgmSel.
  localparam logic [PC_W_DEF-1:0] START_PC [4] = '{10'h000, 10'h040, 10'h100, 10'h200};

endpackage
`default_nettype wire

// File: rtl/run_sequencer_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Up-counter with synchronous clear that sticks at all-ones.           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Q
);

  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      Q <= '0;
    end else if (Inc && (Q != {W{1'b1}})) begin
      Q <= Q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | run_sequencer                                                        |
// | Turns a Start rising edge into a reset/run/done cycle for the core.  |
// | Optional macro WATCHDOG_EN adds a RUN-cycle timeout (WDOG_LIMIT).    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module run_sequencer
  import seq_pkg::*;
#(
  parameter int CYC_W    = CYC_W_DEF,
  parameter int PC_W     = PC_W_DEF,
  parameter int INIT_CYC = 2
`ifdef WATCHDOG_EN
  ,
  parameter int WDOG_LIMIT = 'h4000
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       PgmSel,
  input  logic             CoreAck,
  output logic             CoreReset,
  output logic             PcEn,
  output logic [PC_W-1:0]  StartPc,
  output logic             Busy,
  output logic             Done,
  output logic [CYC_W-1:0] CycleCt,
  output logic             TimedOut
);

  localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              start_q;
  logic              start_edge;
  logic              launch;
  logic              init_last;
  logic [INIT_W-1:0] init_cnt;
  logic [PC_W-1:0]   start_pc;

  assign start_edge = Start & ~start_q;
  assign init_last  = (init_cnt == INIT_W'(INIT_CYC - 1));

`ifdef WATCHDOG_EN
  logic wdog_hit;
  logic timed_out;

  // Compare in 32 bits so a limit beyond the counter range simply never fires.
  assign wdog_hit = (32'(CycleCt) == 32'(WDOG_LIMIT - 1));

  always_ff @(posedge Clk) begin
    if (Reset || launch) begin
      timed_out <= 1'b0;
    end else if ((state == RUN) && !CoreAck && wdog_hit) begin
      timed_out <= 1'b1;
    end
  end

  assign TimedOut = timed_out;
`else
  assign TimedOut = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_edge) begin
          state_nxt = INIT;
          launch    = 1'b1;
        end
      end
      INIT: begin
        if (init_last) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (CoreAck) begin
          state_nxt = DONE;
        end
`ifdef WATCHDOG_EN
        else if (wdog_hit) begin
          state_nxt = DONE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      start_q  <= 1'b0;
      init_cnt <= '0;
      start_pc <= '0;
    end else begin
      start_q <= Start;
      if (launch) begin
        init_cnt <= '0;
        start_pc <= PC_W'(START_PC[PgmSel]);
      end else if (state == INIT) begin
        init_cnt <= init_cnt + INIT_W'(1);
      end
    end
  end

  sat_counter #(
    .W(CYC_W)
  ) u_cycle_ct (
    .Clk  (Clk),
    .Reset(Reset),
    .Clr  (launch),
    .Inc  (state == RUN),
    .Q    (CycleCt)
  );

  assign CoreReset = (state == INIT);
  assign PcEn      = (state == RUN);
  assign Busy      = (state == INIT) || (state == RUN);
  assign Done      = (state == DONE);
  assign StartPc   = start_pc;

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_run_sequencer                                                     |
// | Directed self-checking bench for run_sequencer (WATCHDOG_EN aware).  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  pgm;
  logic        ack;
  logic        core_reset, pc_en, busy, done, timed_out;
  logic [9:0]  start_pc;
  logic [15:0] cycle_ct;

  logic        start4;
  logic [1:0]  pgm4;
  logic        ack4;
  logic        core_reset4, pc_en4, busy4, done4, timed_out4;
  logic [9:0]  start_pc4;
  logic [3:0]  cycle_ct4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_sequencer #(
    .CYC_W(16), .PC_W(10), .INIT_CYC(2)
`ifdef WATCHDOG_EN
    , .WDOG_LIMIT(16)
`endif
  ) dut (
    .Clk(clk), .Reset(rst), .Start(start), .PgmSel(pgm), .CoreAck(ack),
    .CoreReset(core_reset), .PcEn(pc_en), .StartPc(start_pc), .Busy(busy),
    .Done(done), .CycleCt(cycle_ct), .TimedOut(timed_out)
  );

  run_sequencer #(
    .CYC_W(4), .PC_W(10), .INIT_CYC(2)
`ifdef WATCHDOG_EN
    , .WDOG_LIMIT(100)
`endif
  ) dut4 (
    .Clk(clk), .Reset(rst), .Start(start4), .PgmSel(pgm4), .CoreAck(ack4),
    .CoreReset(core_reset4), .PcEn(pc_en4), .StartPc(start_pc4), .Busy(busy4),
    .Done(done4), .CycleCt(cycle_ct4), .TimedOut(timed_out4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pgm = 2'd0; ack = 1'b0;
    start4 = 1'b0; pgm4 = 2'd0; ack4 = 1'b0;

    // 1: reset, with a Start pulse that must be ignored
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    check("idle_core_reset", core_reset, 0);
    check("idle_pc_en", pc_en, 0);
    check("idle_start_pc", start_pc, 0);
    check("idle_done", done, 0);
    check("idle_cycle_ct", cycle_ct, 0);
    check("idle_timed_out", timed_out, 0);
    tick();
    check("idle_stays_idle", busy, 0);

    // 2: program 1, INIT for two cycles, ack in the 10th RUN cycle
    pgm = 2'd1; start = 1'b1;
    tick();
    check("init1_core_reset", core_reset, 1);
    check("init1_start_pc", start_pc, 10'h040);
    check("init1_pc_en", pc_en, 0);
    check("init1_busy", busy, 1);
    tick();
    check("init2_core_reset", core_reset, 1);
    tick();
    check("run_core_reset", core_reset, 0);
    check("run_pc_en", pc_en, 1);
    check("run_cycle_ct0", cycle_ct, 0);
    ticks(9);
    check("run_cycle_ct9", cycle_ct, 9);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_done", done, 1);
    check("ack_pc_en", pc_en, 0);
    check("ack_busy", busy, 0);
    check("ack_cycle_ct", cycle_ct, 10);
    tick();
    check("done_hold_ct", cycle_ct, 10);

    // 3: restart from DONE with program 2, then an ignored edge in RUN
    start = 1'b0;
    tick();
    check("done_hold", done, 1);
    pgm = 2'd2; start = 1'b1;
    tick();
    check("restart_done", done, 0);
    check("restart_start_pc", start_pc, 10'h100);
    check("restart_cycle_ct", cycle_ct, 0);
    check("restart_core_reset", core_reset, 1);
    ticks(2);
    check("restart_run", pc_en, 1);
    ticks(3);
    pgm = 2'd0; start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("redge_pc_en", pc_en, 1);
    check("redge_core_reset", core_reset, 0);
    check("redge_start_pc", start_pc, 10'h100);
    check("redge_cycle_ct", cycle_ct, 5);
    tick();
    check("redge_cycle_ct_next", cycle_ct, 6);

    // 4: reset in the middle of RUN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_pc_en", pc_en, 0);
    check("abort_busy", busy, 0);
    check("abort_cycle_ct", cycle_ct, 0);
    check("abort_start_pc", start_pc, 0);
    tick();
    check("abort_idle", busy, 0);

    // 5: no ack - watchdog timeout, or endless RUN without it
    pgm = 2'd3; start = 1'b1;
    tick();
    check("wd_start_pc", start_pc, 10'h200);
    ticks(2);
    check("wd_run", pc_en, 1);
`ifdef WATCHDOG_EN
    ticks(15);
    check("wd_last_run_pc_en", pc_en, 1);
    check("wd_last_run_ct", cycle_ct, 15);
    tick();
    check("wd_done", done, 1);
    check("wd_timed_out", timed_out, 1);
    check("wd_cycle_ct", cycle_ct, 16);
    check("wd_pc_en", pc_en, 0);
`else
    ticks(99);
    check("nowd_pc_en_100", pc_en, 1);
    check("nowd_cycle_ct_100", cycle_ct, 99);
    check("nowd_timed_out", timed_out, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("nowd_done", done, 1);
    check("nowd_cycle_ct", cycle_ct, 100);
`endif
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("rerun_timed_out", timed_out, 0);
    check("rerun_core_reset", core_reset, 1);

    // 6: 4-bit counter saturates at 15
    pgm4 = 2'd1; start4 = 1'b1;
    tick();
    check("sat_start_pc", start_pc4, 10'h040);
    check("sat_core_reset", core_reset4, 1);
    ticks(2);
    check("sat_run", pc_en4, 1);
    ticks(19);
    check("sat_cycle_ct_19", cycle_ct4, 15);
    check("sat_still_run", pc_en4, 1);
    ack4 = 1'b1;
    tick();
    ack4 = 1'b0;
    check("sat_done", done4, 1);
    check("sat_cycle_ct", cycle_ct4, 15);
    check("sat_timed_out", timed_out4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
